// File: rtl/pipeline_hazard_arbiter.sv
// Stall/flush/redirect arbiter for an in-order front end.
// Older stages win; a recovery FSM keeps younger stages flushed.
module pipeline_hazard_arbiter #(
  parameter int NUM_STAGES      = 4,
  parameter int PC_W            = 32,
  parameter int RECOVERY_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_STAGES-1:0]       stage_stall_req,
  input  logic [NUM_STAGES-1:0]       stage_flush_req,
  input  logic [NUM_STAGES-1:0]       redirect_valid,
  input  logic [NUM_STAGES*PC_W-1:0]  redirect_pc,
  input  logic                        cnt_clear,
  output logic [NUM_STAGES-1:0]       hc_stall,
  output logic [NUM_STAGES-1:0]       hc_flush,
  output logic                        load_pc_we,
  output logic [PC_W-1:0]             load_pc_new_pc,
  output logic                        recovering,
  output logic [NUM_STAGES*CNT_W-1:0] stall_evt_cnt,
  output logic [CNT_W-1:0]            redirect_cnt
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CW = (RECOVERY_CYCLES > 0) ?
                      $clog2(RECOVERY_CYCLES + 1) : 1;
  localparam bit HAS_REC = (RECOVERY_CYCLES > 0);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]            state;
  logic [SW-1:0]         rec_stage;
  logic [CW-1:0]         rec_cnt;
  logic                  rec_on;
  logic                  win;
  logic [SW-1:0]         win_k;
  logic [PC_W-1:0]       win_pc;
  logic [SW-1:0]         sq_lim;
  logic [NUM_STAGES-1:0] prev_stall;
  logic [CNT_W-1:0]      scnt [NUM_STAGES];

  assign rec_on     = (state == RECOVER);
  assign recovering = rec_on;

  // Scan upward so the oldest accepted requester is left holding win_k.
  always_comb begin
    win    = 1'b0;
    win_k  = '0;
    win_pc = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (redirect_valid[k] && (!rec_on || SW'(k) >= rec_stage)) begin
        win    = 1'b1;
        win_k  = SW'(k);
        win_pc = redirect_pc[k*PC_W +: PC_W];
      end
    end
  end

  assign load_pc_we     = win;
  assign load_pc_new_pc = win_pc;

  // A new winner is never below rec_stage, so it always sets the boundary.
  always_comb begin
    sq_lim = '0;
    if (rec_on) sq_lim = rec_stage;
    if (win)    sq_lim = win_k;
  end

  always_comb begin
    logic older;
    older    = 1'b0;
    hc_stall = '0;
    hc_flush = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (SW'(i) < sq_lim) begin
        hc_stall[i] = 1'b0;
        hc_flush[i] = 1'b1;
      end else begin
        hc_stall[i] = stage_stall_req[i] | older;
        hc_flush[i] = stage_flush_req[i] & ~older;
      end
      older = hc_stall[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rec_stage <= '0;
      rec_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win && HAS_REC) begin
            state     <= RECOVER;
            rec_stage <= win_k;
            rec_cnt   <= CW'(RECOVERY_CYCLES);
          end
        end
        default: begin
          if (win) begin
            rec_stage <= win_k;
            rec_cnt   <= CW'(RECOVERY_CYCLES);
          end else if (rec_cnt == CW'(1)) begin
            state     <= IDLE;
            rec_stage <= '0;
            rec_cnt   <= '0;
          end else begin
            rec_cnt   <= rec_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stall   <= '0;
      redirect_cnt <= '0;
      for (int i = 0; i < NUM_STAGES; i++) scnt[i] <= '0;
    end else begin
      prev_stall <= stage_stall_req;
      if (cnt_clear) begin
        redirect_cnt <= '0;
        for (int i = 0; i < NUM_STAGES; i++) scnt[i] <= '0;
      end else begin
        if (win && redirect_cnt != CNT_MAX)
          redirect_cnt <= redirect_cnt + 1'b1;
        for (int i = 0; i < NUM_STAGES; i++)
          if (stage_stall_req[i] && !prev_stall[i] && scnt[i] != CNT_MAX)
            scnt[i] <= scnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cnt
    assign stall_evt_cnt[g*CNT_W +: CNT_W] = scnt[g];
  end

endmodule
